// File: rtl/npower_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// npower_bus_arbiter
//
// Shares the single external Wishbone-classic bus of the nPower v1 core between
// the instruction-fetch master (ICU line refill) and the data master (loads and
// stores from MEMORY/MALIGN). Data wins simultaneous requests, but only for
// MAXSTREAK consecutive tenures while fetch is waiting; then fetch is forced in.
// A tenure is never pre-empted. A watchdog aborts a strobe that has stalled for
// TMO cycles and hands an error to the owning master.
//
// Parameters
//   AWID       address width
//   MAXSTREAK  data tenures granted in a row while fetch waits (1..15)
//   TMO        stalled strobe cycles before abort (2..255)
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   icyc_i, istb_i, iadr_i        fetch master request
//   iack_o, ierr_o, idat_o        fetch master response
//   dcyc_i, dstb_i, dwe_i,
//   dsel_i, dadr_i, ddat_i        data master request
//   dack_o, derr_o, ddat_o        data master response
//   cyc_o, stb_o, we_o, sel_o,
//   adr_o, dat_o                  external bus request (mirrors the owner)
//   ack_i, err_i, dat_i           external bus response
//   gnt_o                         owner: 00 none, 01 fetch, 10 data, 11 abort
//   tmo_o                         single-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module npower_bus_arbiter #(
   parameter int AWID      = 32,
   parameter int MAXSTREAK = 4,
   parameter int TMO       = 255
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   // fetch master
   input  logic            icyc_i,
   input  logic            istb_i,
   input  logic [AWID-1:0] iadr_i,
   output logic            iack_o,
   output logic            ierr_o,
   output logic [31:0]     idat_o,
   // data master
   input  logic            dcyc_i,
   input  logic            dstb_i,
   input  logic            dwe_i,
   input  logic [3:0]      dsel_i,
   input  logic [AWID-1:0] dadr_i,
   input  logic [31:0]     ddat_i,
   output logic            dack_o,
   output logic            derr_o,
   output logic [31:0]     ddat_o,
   // external bus
   output logic            cyc_o,
   output logic            stb_o,
   output logic            we_o,
   output logic [3:0]      sel_o,
   output logic [AWID-1:0] adr_o,
   output logic [31:0]     dat_o,
   input  logic            ack_i,
   input  logic            err_i,
   input  logic [31:0]     dat_i,
   // status
   output logic [1:0]      gnt_o,
   output logic            tmo_o
);

   // State codes double as the gnt_o status encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      IGNT  = 2'b01,
      DGNT  = 2'b10,
      ABORT = 2'b11
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAXSTREAK);
   localparam logic [7:0] WDOG_LAST  = 8'(TMO - 1);

   state_t     state;
   logic [3:0] streak;      // data tenures granted while fetch was requesting
   logic [7:0] wdog;        // consecutive stalled strobe cycles
   logic       abort_data;  // owner at abort time was the data master

   logic own_i;
   logic own_d;
   logic stall;
   logic fire;

   assign own_i = (state == IGNT);
   assign own_d = (state == DGNT);

   // ------------------------------------------------------------------------
   // Bus mux: driven from the state register so an asynchronous reset drops
   // cyc_o immediately, without waiting for a clock.
   // ------------------------------------------------------------------------
   always_comb begin
      cyc_o = 1'b0;
      stb_o = 1'b0;
      we_o  = 1'b0;
      sel_o = '0;
      adr_o = '0;
      dat_o = '0;
      case (state)
         IGNT: begin
            cyc_o = icyc_i;
            stb_o = istb_i;
            we_o  = 1'b0;
            sel_o = '1;
            adr_o = iadr_i;
         end
         DGNT: begin
            cyc_o = dcyc_i;
            stb_o = dstb_i;
            we_o  = dwe_i;
            sel_o = dsel_i;
            adr_o = dadr_i;
            dat_o = ddat_i;
         end
         default: ;
      endcase
   end

   // A stalled cycle is a strobe with no response; the watchdog fires on the
   // TMO-th one (counter starts at 0 on the first stalled cycle).
   assign stall = stb_o & ~ack_i & ~err_i;
   assign fire  = (own_i | own_d) & stall & (wdog == WDOG_LAST);

   // Response routing: err wins over a simultaneous ack; watchdog error goes
   // to the owner in the same cycle it fires.
   assign iack_o = own_i & ack_i & ~err_i;
   assign ierr_o = own_i & (err_i | fire);
   assign dack_o = own_d & ack_i & ~err_i;
   assign derr_o = own_d & (err_i | fire);

   // Read data is broadcast; only the acknowledged master samples it.
   assign idat_o = dat_i;
   assign ddat_o = dat_i;

   assign tmo_o = fire;
   assign gnt_o = state;

   // ------------------------------------------------------------------------
   // Arbitration state machine, streak counter and watchdog.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         streak     <= '0;
         wdog       <= '0;
         abort_data <= 1'b0;
      end else begin
         if ((own_i | own_d) && stall) begin
            wdog <= wdog + 8'd1;
         end else begin
            wdog <= '0;
         end

         case (state)
            IDLE: begin
               // Any decision taken with fetch idle forgets the streak.
               if (!icyc_i) begin
                  streak <= '0;
               end
               if (dcyc_i && (!icyc_i || (streak < STREAK_MAX))) begin
                  state <= DGNT;
                  if (icyc_i && (streak != '1)) begin
                     streak <= streak + 4'd1;
                  end
               end else if (icyc_i) begin
                  state  <= IGNT;
                  streak <= '0;
               end
            end
            IGNT: begin
               if (fire) begin
                  state      <= ABORT;
                  abort_data <= 1'b0;
               end else if (!icyc_i) begin
                  state <= IDLE;
               end
            end
            DGNT: begin
               if (fire) begin
                  state      <= ABORT;
                  abort_data <= 1'b1;
               end else if (!dcyc_i) begin
                  state <= IDLE;
               end
            end
            ABORT: begin
               // Hold the bus off until the aborted master ends its cycle.
               if (!(abort_data ? dcyc_i : icyc_i)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_npower_bus_arbiter.sv
`timescale 1ns/1ps
module tb_npower_bus_arbiter;

   localparam int MAXS = 4;
   localparam int TMOV = 8;

   logic        clk;
   logic        rst_ni;
   logic        icyc, istb;
   logic [31:0] iadr;
   logic        iack_o, ierr_o;
   logic [31:0] idat_o;
   logic        dcyc, dstb, dwe;
   logic [3:0]  dsel;
   logic [31:0] dadr, ddat;
   logic        dack_o, derr_o;
   logic [31:0] ddat_o;
   logic        cyc_o, stb_o, we_o;
   logic [3:0]  sel_o;
   logic [31:0] adr_o, dat_o;
   logic        ack_i, err_i;
   logic [31:0] dat_i;
   logic [1:0]  gnt_o;
   logic        tmo_o;

   npower_bus_arbiter #(.AWID(32), .MAXSTREAK(MAXS), .TMO(TMOV)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .icyc_i(icyc), .istb_i(istb), .iadr_i(iadr),
      .iack_o(iack_o), .ierr_o(ierr_o), .idat_o(idat_o),
      .dcyc_i(dcyc), .dstb_i(dstb), .dwe_i(dwe), .dsel_i(dsel),
      .dadr_i(dadr), .ddat_i(ddat),
      .dack_o(dack_o), .derr_o(derr_o), .ddat_o(ddat_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
      .adr_o(adr_o), .dat_o(dat_o),
      .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
      .gnt_o(gnt_o), .tmo_o(tmo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // ---------------- slave model ----------------
   logic        slave_en  = 1'b0;
   logic        ack_force = 1'b0;
   logic        err_drv   = 1'b0;
   int unsigned smax      = 0;
   int unsigned sdelay    = 0;
   int unsigned stall     = 0;

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   assign ack_i = ack_force | (slave_en & cyc_o & stb_o & (stall >= sdelay));
   assign err_i = err_drv;
   assign dat_i = rd_of(adr_o);

   always @(posedge clk) begin
      if (cyc_o && stb_o && !ack_i) begin
         stall <= stall + 1;
      end else begin
         stall <= 0;
         if (ack_i) sdelay <= $urandom_range(smax, 0);
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] rd;
   } beat_t;

   beat_t      iq[$];
   beat_t      dq[$];
   logic [1:0] gq[$];
   logic       gchk = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int unsigned i_drop_cyc = 0;
   int unsigned d_start_cyc = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string msg);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, msg);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input logic is_d);
      int  n;
      logic got;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         got = is_d ? (dack_o | derr_o) : (iack_o | ierr_o);
      end
      if (!got) begin
         if (is_d) fail("d_resp_wait", "got no response, required one within 200 cycles");
         else      fail("i_resp_wait", "got no response, required one within 200 cycles");
      end
   endtask

   task automatic i_tenure(input int nb, input int gap);
      beat_t e;
      for (int b = 0; b < nb; b++) begin
         e.adr = $urandom;
         e.we  = 1'b0;
         e.sel = 4'hF;
         e.dat = '0;
         e.rd  = rd_of(e.adr);
         iq.push_back(e);
         icyc = 1'b1;
         istb = 1'b1;
         iadr = e.adr;
         wait_resp(1'b0);
         tick(1);
      end
      icyc = 1'b0;
      istb = 1'b0;
      i_drop_cyc = cyc_n;
      tick(gap + 1);
   endtask

   task automatic d_tenure(input int nb, input int gap);
      beat_t e;
      for (int b = 0; b < nb; b++) begin
         e.adr = $urandom;
         e.we  = 1'($urandom_range(1, 0));
         e.sel = 4'($urandom_range(15, 1));
         e.dat = $urandom;
         e.rd  = rd_of(e.adr);
         dq.push_back(e);
         dcyc = 1'b1;
         dstb = 1'b1;
         dadr = e.adr;
         dwe  = e.we;
         dsel = e.sel;
         ddat = e.dat;
         wait_resp(1'b1);
         tick(1);
      end
      dcyc = 1'b0;
      dstb = 1'b0;
      dwe  = 1'b0;
      tick(gap + 1);
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [1:0]  prev_gnt;
      logic        prev_icyc;
      int unsigned wstreak;
      beat_t       e;
      logic [1:0]  g;
      prev_gnt  = '0;
      prev_icyc = 1'b0;
      wstreak   = 0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            prev_gnt  = '0;
            prev_icyc = 1'b0;
            wstreak   = 0;
         end else begin
            if ((gnt_o == 2'b01 || gnt_o == 2'b10) && gnt_o != prev_gnt) begin
               check("tenure_gap", 128'(prev_gnt), 128'(2'b00));
               if (gnt_o == 2'b10) begin
                  d_start_cyc = cyc_n;
                  if (prev_icyc) wstreak++;
               end else begin
                  check("streak_bound", 128'(wstreak <= MAXS), 128'(1'b1));
                  wstreak = 0;
               end
               if (gchk) begin
                  if (gq.size() == 0) begin
                     fail("grant_order", "got an extra tenure, required none");
                  end else begin
                     g = gq.pop_front();
                     check("grant_order", 128'(gnt_o), 128'(g));
                  end
               end
            end
            if (!icyc) wstreak = 0;

            if (iack_o) begin
               check("ack_excl", 128'(dack_o), 128'(1'b0));
               if (iq.size() == 0) begin
                  fail("ibeat", "got a fetch ack, required none pending");
               end else begin
                  e = iq.pop_front();
                  check("ibeat", 128'({adr_o, we_o, sel_o, idat_o}),
                        128'({e.adr, 1'b0, 4'hF, e.rd}));
               end
            end
            if (dack_o) begin
               if (dq.size() == 0) begin
                  fail("dbeat", "got a data ack, required none pending");
               end else begin
                  e = dq.pop_front();
                  check("dbeat", 128'({adr_o, we_o, sel_o, (we_o ? dat_o : 32'h0), ddat_o}),
                        128'({e.adr, e.we, e.sel, (e.we ? e.dat : 32'h0), e.rd}));
               end
            end
            if (ack_i && !err_i && cyc_o && stb_o && !iack_o && !dack_o)
               fail("ack_route", "got bus ack to neither master, required owner ack");
            prev_gnt  = gnt_o;
            prev_icyc = icyc;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      beat_t       e;
      int          stalls;
      int          n;
      logic        seen;
      logic        tmo_seen;

      rst_ni = 1'b0;
      icyc = 1'b1; istb = 1'b1; iadr = 32'h0000_0200;
      dcyc = 1'b1; dstb = 1'b1; dadr = 32'h0000_0100;
      dwe = 1'b1; dsel = 4'hF; ddat = 32'h1234_5678;

      // Reset held with both masters requesting.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_bus",  128'({cyc_o, stb_o, we_o}), 128'(3'b000));
      check("rst_resp", 128'({iack_o, ierr_o, dack_o, derr_o, tmo_o}), 128'(5'b0));
      check("rst_gnt",  128'(gnt_o), 128'(2'b00));
      tick(1);
      rst_ni = 1'b1;
      @(negedge clk);
      check("rel_idle", 128'({gnt_o, cyc_o}), 128'(3'b000));
      @(negedge clk);
      check("rel_dgnt", 128'({gnt_o, cyc_o}), 128'(3'b101));
      tick(1);
      icyc = 1'b0; istb = 1'b0; dcyc = 1'b0; dstb = 1'b0; dwe = 1'b0;
      tick(3);

      // Single fetch, ack in the third bus cycle.
      e.adr = 32'h0000_1230; e.we = 1'b0; e.sel = 4'hF; e.dat = '0; e.rd = rd_of(e.adr);
      iq.push_back(e);
      icyc = 1'b1; istb = 1'b1; iadr = e.adr;
      tick(1);
      @(negedge clk);
      check("if_b1", 128'({iack_o, dack_o, gnt_o}), 128'(4'b0001));
      tick(1);
      @(negedge clk);
      check("if_b2", 128'({iack_o, dack_o}), 128'(2'b00));
      tick(1);
      ack_force = 1'b1;
      @(negedge clk);
      check("if_ack", 128'({iack_o, ierr_o, dack_o, derr_o}), 128'(4'b1000));
      tick(1);
      ack_force = 1'b0; icyc = 1'b0; istb = 1'b0;
      @(negedge clk);
      check("if_drop", 128'(gnt_o), 128'(2'b01));
      tick(1);
      @(negedge clk);
      check("if_idle", 128'(gnt_o), 128'(2'b00));
      tick(1);

      // Continuous contention, single-beat tenures.
      slave_en = 1'b1;
      smax = 0;
      for (int k = 0; k < 10; k++) gq.push_back((k % (MAXS + 1) == MAXS) ? 2'b01 : 2'b10);
      gchk = 1'b1;
      fork
         repeat (8) d_tenure(1, 0);
         repeat (2) i_tenure(1, 0);
      join
      gchk = 1'b0;
      check("order_done", 128'(gq.size()), 128'(0));
      tick(2);

      // Fetch burst of 4 with data arriving at beat 2.
      fork
         i_tenure(4, 0);
         begin tick(2); d_tenure(1, 0); end
      join
      check("burst_dstart", 128'(d_start_cyc - i_drop_cyc), 128'(2));

      // Watchdog timeout on a stalled data strobe.
      slave_en = 1'b0;
      dcyc = 1'b1; dstb = 1'b1; dwe = 1'b0; dsel = 4'hF; dadr = 32'hDEAD_0000;
      stalls = 0; n = 0; seen = 1'b0; tmo_seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (gnt_o == 2'b10) stalls++;
         if (derr_o) begin
            seen = 1'b1;
            tmo_seen = tmo_o;
         end
      end
      check("tmo_cycle", 128'(stalls), 128'(TMOV));
      check("tmo_pulse", 128'(tmo_seen), 128'(1'b1));
      @(negedge clk);
      check("abort_state", 128'({gnt_o, cyc_o, stb_o, derr_o, tmo_o}), 128'(6'b110000));
      tick(1);
      @(negedge clk);
      check("abort_hold", 128'(gnt_o), 128'(2'b11));
      tick(1);
      dcyc = 1'b0; dstb = 1'b0;
      @(negedge clk);
      check("abort_wait", 128'(gnt_o), 128'(2'b11));
      tick(1);
      @(negedge clk);
      check("abort_exit", 128'(gnt_o), 128'(2'b00));

      // Simultaneous ack and err: owner sees err only.
      tick(1);
      dcyc = 1'b1; dstb = 1'b1; dadr = 32'h0000_4000;
      tick(1);
      ack_force = 1'b1; err_drv = 1'b1;
      @(negedge clk);
      check("ack_err", 128'({iack_o, ierr_o, dack_o, derr_o, tmo_o, gnt_o}), 128'(7'b0001010));
      tick(1);
      ack_force = 1'b0; err_drv = 1'b0; dcyc = 1'b0; dstb = 1'b0;
      tick(2);

      // Reset asserted in the second beat of a fetch burst.
      e.adr = 32'h0000_8000; e.we = 1'b0; e.sel = 4'hF; e.dat = '0; e.rd = rd_of(e.adr);
      iq.push_back(e);
      icyc = 1'b1; istb = 1'b1; iadr = e.adr;
      tick(1);
      ack_force = 1'b1;
      @(negedge clk);
      tick(1);
      ack_force = 1'b0;
      iadr = 32'h0000_8004;
      @(negedge clk);
      #2;
      check("pre_rst_cyc", 128'({cyc_o, gnt_o}), 128'(3'b101));
      rst_ni = 1'b0;
      #1;
      check("async_rst", 128'({cyc_o, stb_o, gnt_o}), 128'(4'b0000));
      icyc = 1'b0; istb = 1'b0;
      tick(2);
      rst_ni = 1'b1;
      tick(2);

      // Randomized traffic from both masters.
      slave_en = 1'b1;
      smax = 3;
      fork
         for (int t = 0; t < 40; t++) d_tenure($urandom_range(4, 1), $urandom_range(3, 0));
         for (int t = 0; t < 40; t++) i_tenure($urandom_range(4, 1), $urandom_range(3, 0));
      join
      tick(3);
      check("iq_empty", 128'(iq.size()), 128'(0));
      check("dq_empty", 128'(dq.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : guard
      #2000000;
      $display("FAIL global_timeout: got no end of test, required finish within 2 ms");
      $fatal(1, "simulation did not terminate");
   end

endmodule

// File: doc/npower_bus_arbiter.md
# npower_bus_arbiter

Two-master bus arbiter for the nPower v1 core. It shares the single external Wishbone-classic bus between the instruction-fetch master (IFETCH/ICU cache-line refill) and the data-memory master (MEMORY/MALIGN loads and stores). Data has priority, with a bounded streak so fetch cannot starve. A bus-timeout watchdog returns an error to the owning master so the core can raise FLT_MACHINE_CHECK.

## Interface
Parameters:
- AWID, 32, address width.
- MAXSTREAK, 4, consecutive data tenures granted while fetch waits before fetch is forced in (range 1–15).
- TMO, 255, cycles stb_o may stay high without ack_i/err_i before abort (range 2–255; counter is 8 bits).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- icyc_i, istb_i  in  1  fetch master cycle and strobe.
- iadr_i  in  AWID  fetch address.
- iack_o, ierr_o  out  1  fetch acknowledge and error.
- idat_o  out  32  fetch read data.
- dcyc_i, dstb_i, dwe_i  in  1  data master cycle, strobe and write enable.
- dsel_i  in  4  data byte selects.
- dadr_i  in  AWID  data address.
- ddat_i  in  32  data write data.
- dack_o, derr_o  out  1  data acknowledge and error.
- ddat_o  out  32  data read data.
- cyc_o, stb_o, we_o  out  1  bus cycle, strobe and write enable.
- sel_o  out  4  bus byte selects.
- adr_o  out  AWID  bus address.
- dat_o  out  32  bus write data.
- ack_i, err_i  in  1  bus acknowledge and error.
- dat_i  in  32  bus read data.
- gnt_o  out  2  owner status: 00 none, 01 fetch, 10 data, 11 abort.
- tmo_o  out  1  one-cycle pulse when a timeout fires.

## Operation
State machine, with the state held in a register:
- IDLE
  - dcyc_i=1 and (icyc_i=0 or streak<MAXSTREAK) → DGNT. If icyc_i=1 at this decision, streak increments (saturating).
  - Otherwise icyc_i=1 → IGNT, and streak clears.
  - icyc_i=0 at any decision also clears streak.
- DGNT / IGNT
  - The bus mirrors the owner: cyc_o, stb_o, adr_o, sel_o, we_o, dat_o come combinationally from the owner's inputs. Fetch drives we_o=0 and sel_o=4'hF.
  - When the owner drops its cyc input, the next state is IDLE. A tenure may span any number of beats (burst, MALIGN pairs); the grant is never pre-empted.
- ABORT
  - cyc_o=stb_o=0.
  - Waits until the previous owner's cyc input is 0, then goes to IDLE.

Datapath and watchdog rules:
- ack_i and err_i route combinationally only to the owner in DGNT/IGNT. They are 0 to the non-owner and 0 to both masters in IDLE and ABORT.
- idat_o and ddat_o are both dat_i (broadcast); only the acknowledged master samples it.
- Watchdog counter:
  - Clears in IDLE/ABORT, and in any cycle with stb_o=0, ack_i=1 or err_i=1.
  - Otherwise increments.
  - When it equals TMO-1 while stb_o=1 and ack_i=err_i=0, that cycle asserts the owner's err output and tmo_o, and the next state is ABORT.
- Simultaneous ack_i and err_i: err wins; the owner sees err only.

Reset values (rst_ni low, asynchronous):
- State is IDLE; streak=0; watchdog=0.
- cyc_o, stb_o, we_o, iack_o, ierr_o, dack_o, derr_o, tmo_o are 0; gnt_o=00.
- Because the bus mux is driven from state, reset mid-tenure drops cyc_o immediately, without waiting for a clock.

## Timing
- Grant latency: a request seen in IDLE at edge N gives cyc_o=1 during cycle N+1. A request arriving while another master owns the bus is served no earlier than the second edge after that owner drops cyc.
- There is always at least one IDLE cycle between tenures, including back-to-back tenures by the same master.
- Ack path is zero-latency (combinational). A slave acking in the same cycle as stb_o gives single-cycle beats.
- Timeout: err is asserted in the TMO-th consecutive stalled strobe cycle. The bus goes low on the following cycle.
- Simultaneous requests in IDLE: data wins unless streak==MAXSTREAK.

## Test plan
- Reset: hold rst_ni=0 with both cyc inputs high → all outputs 0 and gnt_o=00. Release → data granted first; cyc_o high in the second cycle after release.
- Single fetch: icyc_i/istb_i held, ack_i on the 3rd bus cycle → iack_o in exactly that cycle, dack_o stays 0, and IDLE follows one cycle after icyc_i drops.
- Contention with MAXSTREAK=4: both masters request continuously with 1-beat tenures → grant order D,D,D,D,I,D,D,D,D,I, with one idle cycle between each tenure.
- 4-beat fetch burst while dcyc_i rises at beat 2 → fetch is not pre-empted; the data grant starts the second cycle after icyc_i drops.
- Timeout with TMO=8: data stb held and no ack → derr_o and tmo_o pulse in the 8th stall cycle. Next cycle gnt_o=11 and cyc_o=0. Dropping dcyc_i returns to IDLE.
- Simultaneous ack_i=err_i=1 → the owner sees err only. A reset asserted mid-burst → cyc_o falls without waiting for a clock edge.
